// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, FSM encoding and high-count helper for the PWM channels
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int CNT_W_DEF  = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  // High time in cycles; for any duty below 2^duty_w the result never exceeds fv.
  function automatic logic [31:0] calc_hi(input logic [31:0] fv,
                                          input logic [31:0] duty,
                                          input int          duty_w);
    logic [63:0] prod;
    prod = ({32'd0, fv} + 64'd1) * {32'd0, duty};
    prod = prod >> duty_w;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - period counter holding the active terminal count
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_fv,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic             o_wrap,
  output logic             o_period_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_fv;
  logic             w_last;

  assign w_last       = i_run && (r_cnt == r_act_fv);
  assign o_wrap       = w_last;
  assign o_period_end = w_last;

  // A load always restarts the period at zero; outside RUN the count is parked at zero.
  always_comb begin
    o_cnt_next = '0;
    if (i_run && !w_last && !i_load) begin
      o_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_act_fv <= '0;
    end else begin
      r_cnt <= o_cnt_next;
      if (i_load) begin
        r_act_fv <= i_load_fv;
      end
    end
  end

endmodule

// File: rtl/pwm_channel_gen.sv
// rtl/pwm_channel_gen.sv - one PWM channel with capture handshake and period-boundary double buffering
module pwm_channel_gen
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DUTY_W-1:0] i_Duty,
  input  logic              i_Duty_Valid,
  input  logic [CNT_W-1:0]  i_Final_Value,
  input  logic              i_Final_Value_Valid,
  output logic              o_done,
  output logic              o_pwm,
  output logic              o_period_end,
  output logic              o_active
);

  pwm_state_e       r_state;
  pwm_state_e       w_state_next;
  logic             r_ack_pend;
  logic             r_pend_vld;
  logic             r_done;
  logic             r_pwm;
  logic [CNT_W-1:0] r_pend_fv;
  logic [CNT_W-1:0] r_pend_hi;
  logic [CNT_W-1:0] r_act_hi;
  logic [CNT_W-1:0] w_cap_hi;
  logic [CNT_W-1:0] w_hi_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cap;
  logic             w_load;
  logic             w_wrap;
  logic             w_run;

  assign w_cap    = i_Duty_Valid & i_Final_Value_Valid & ~r_ack_pend;
  assign w_cap_hi = CNT_W'(calc_hi(32'(i_Final_Value), 32'(i_Duty), DUTY_W));
  assign w_run    = (r_state == ST_RUN);

  assign o_done   = r_done;
  assign o_pwm    = r_pwm;
  assign o_active = w_run;

  pwm_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (w_run),
    .i_load       (w_load),
    .i_load_fv    (r_pend_fv),
    .o_cnt_next   (w_cnt_next),
    .o_wrap       (w_wrap),
    .o_period_end (o_period_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A zero terminal count means the channel is disabled.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (r_pend_vld && (r_pend_fv != '0)) w_state_next = ST_RUN;
      ST_RUN:  if (w_wrap && r_pend_vld && (r_pend_fv == '0)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = r_pend_vld;
      ST_RUN:  w_load = w_wrap & r_pend_vld;
      default: w_load = 1'b0;
    endcase
    w_hi_next = w_load ? r_pend_hi : r_act_hi;
  end

  // The boundary load consumes the old pending pair before a same-cycle capture refills it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done     <= 1'b0;
      r_ack_pend <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_fv  <= '0;
      r_pend_hi  <= '0;
      r_act_hi   <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_done <= w_cap;
      if (w_cap) begin
        r_ack_pend <= 1'b1;
      end else if (!(i_Duty_Valid && i_Final_Value_Valid)) begin
        r_ack_pend <= 1'b0;
      end
      if (w_cap) begin
        r_pend_fv  <= i_Final_Value;
        r_pend_hi  <= w_cap_hi;
        r_pend_vld <= 1'b1;
      end else if (w_load) begin
        r_pend_vld <= 1'b0;
      end
      if (w_load) begin
        r_act_hi <= r_pend_hi;
      end
      r_pwm <= (w_state_next == ST_RUN) && (w_cnt_next < w_hi_next);
    end
  end

endmodule

// File: tb/tb_pwm_channel_gen.sv
// tb/tb_pwm_channel_gen.sv - randomized upstream writer checked against a timestamp-based period model
module tb_pwm_channel_gen;
  import pwm_pkg::*;

  localparam int DW    = DUTY_W_DEF;
  localparam int CW    = CNT_W_DEF;
  localparam int N_CYC = 20000;
  localparam int N_DIR = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] duty;
  logic          duty_vld;
  logic [CW-1:0] fval;
  logic          fval_vld;
  logic          done;
  logic          pwm;
  logic          period_end;
  logic          active;

  always #5 clk = ~clk;

  pwm_channel_gen #(
    .DUTY_W (DW),
    .CNT_W  (CW)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_Duty              (duty),
    .i_Duty_Valid        (duty_vld),
    .i_Final_Value       (fval),
    .i_Final_Value_Valid (fval_vld),
    .o_done              (done),
    .o_pwm               (pwm),
    .o_period_end        (period_end),
    .o_active            (active)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, t);
    end
  endtask

  // Reference: the active period is described by its start cycle, length and high time.
  bit m_run, m_pvld, m_busy, m_done;
  int m_fv, m_hi, m_start, m_pfv, m_phi;

  task automatic model_clear();
    m_run = 0; m_pvld = 0; m_busy = 0; m_done = 0;
    m_fv = 0; m_hi = 0; m_start = 0; m_pfv = 0; m_phi = 0;
  endtask

  task automatic model_edge(input bit r, input bit dv, input bit fvv, input int d, input int fv);
    if (r) begin
      model_clear();
    end else begin
      if (!m_run || (t - m_start) == m_fv) begin
        if (m_pvld) begin
          m_pvld = 0;
          if (m_pfv == 0) begin
            m_run = 0;
          end else begin
            m_run = 1; m_fv = m_pfv; m_hi = m_phi; m_start = t + 1;
          end
        end else if (m_run) begin
          m_start = t + 1;
        end
      end
      if (dv && fvv && !m_busy) begin
        m_pvld = 1; m_pfv = fv; m_phi = ((fv + 1) * d) / (1 << DW);
        m_busy = 1; m_done = 1;
      end else begin
        m_done = 0;
        if (!(dv && fvv)) m_busy = 0;
      end
    end
    t++;
  endtask

  int  dir_fv [N_DIR] = '{9, 19, 99, 255, 0, 3};
  int  dir_d  [N_DIR] = '{128, 64, 0, 255, 0, 128};
  int  wr_idx = 0;
  int  ag_st = 0, ag_cnt = 2, ag_budget = 0;
  bit  ag_wrapwait = 0;
  int  cur_d = 0, cur_fv = 0;
  int  next_rst = 3000;
  bit  e_pwm, e_pe, e_act;

  task automatic pick_write();
    if (wr_idx < N_DIR) begin
      cur_fv = dir_fv[wr_idx];
      cur_d  = dir_d[wr_idx];
    end else begin
      case ($urandom_range(0, 9))
        0:       cur_fv = 0;
        1, 2:    cur_fv = $urandom_range(1, 3);
        3:       cur_fv = $urandom_range(200, 300);
        default: cur_fv = $urandom_range(4, 30);
      endcase
      case ($urandom_range(0, 4))
        0:       cur_d = 0;
        1:       cur_d = (1 << DW) - 1;
        default: cur_d = $urandom_range(0, (1 << DW) - 1);
      endcase
    end
    wr_idx++;
    duty = DW'(cur_d);
    fval = CW'(cur_fv);
    duty_vld = 1'b1;
    fval_vld = 1'b1;
  endtask

  task automatic drop();
    ag_st       = 0;
    ag_cnt      = (wr_idx <= N_DIR) ? $urandom_range(20, 60) : $urandom_range(0, 6);
    ag_wrapwait = ($urandom_range(0, 2) == 0);
    ag_budget   = 400;
    duty_vld    = 1'b0;
    fval_vld    = 1'b0;
    duty        = DW'($urandom_range(0, 255));
    fval        = CW'($urandom_range(0, 1023));
  endtask

  task automatic gap_noise();
    if ($urandom_range(0, 1) == 1) begin
      duty_vld = ($urandom_range(0, 3) == 0);
      fval_vld = 1'b0;
    end else begin
      duty_vld = 1'b0;
      fval_vld = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; duty = '0; fval = '0; duty_vld = 1'b0; fval_vld = 1'b0;
    model_clear();
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      model_edge(rst, duty_vld, fval_vld, int'(duty), int'(fval));
      @(negedge clk);
      e_act = m_run;
      e_pwm = m_run && ((t - m_start) < m_hi);
      e_pe  = m_run && ((t - m_start) == m_fv);
      check("done",       32'(done),       32'(m_done));
      check("pwm",        32'(pwm),        32'(e_pwm));
      check("period_end", 32'(period_end), 32'(e_pe));
      check("active",     32'(active),     32'(e_act));

      if (cyc < 3) begin
        rst = 1'b1;
      end else if (cyc >= next_rst && e_pwm) begin
        rst = 1'b1;
        duty_vld = 1'b0; fval_vld = 1'b0;
        ag_st = 0; ag_cnt = 3; ag_wrapwait = 0;
        next_rst += 5000;
      end else begin
        rst = 1'b0;
        case (ag_st)
          0: begin
            if (ag_cnt > 0) begin
              ag_cnt--;
              gap_noise();
            end else if (ag_wrapwait && ag_budget > 0 && !(m_run && (t - m_start) == m_fv)) begin
              ag_budget--;
              gap_noise();
            end else begin
              pick_write();
              ag_st = 1;
            end
          end
          1: begin
            if (m_done) begin
              ag_cnt = $urandom_range(0, 3);
              if (ag_cnt == 0) drop();
              else ag_st = 2;
            end
          end
          default: begin
            ag_cnt--;
            if (ag_cnt <= 0) drop();
          end
        endcase
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
